// File: rtl/aes_iter_core_if.sv
// Block-stream and round-key handshake bundle for aes_iter_core.
// master = host / key store side, slave = cipher core.
interface aes_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_dec;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_dec, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dec, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 engine: one round per clock over a shared round datapath.
// Define AES_DEC_EN to build the decrypt path; without it the core is encrypt-only.
module aes_iter_core #(
  parameter int NR = 10
) (
  input logic            clk,
  input logic            rst_n,
  aes_iter_core_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [3:0] NR_L  = 4'(NR);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_iter_core: NR must be 10, 12 or 14");
  end

  logic [1:0]   fsm_r;
  logic [127:0] state_r;
  logic [127:0] out_data_r;
  logic [3:0]   cnt_r;
  logic [3:0]   rk_idx_r;
  logic         mode_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [127:0] round_out_s;
  logic         accept_dec_s;
  logic         last_s;
  logic         nomix_s;

`ifdef AES_DEC_EN
  assign accept_dec_s = bus.in_dec;
`else
  logic unused_in_dec;
  assign unused_in_dec = bus.in_dec;
  assign accept_dec_s  = 1'b0;
`endif

  assign last_s  = (cnt_r == NR_L);
  // Final encrypt round drops MixColumns; first decrypt round drops InvMixColumns.
  assign nomix_s = mode_r ? (cnt_r == 4'd1) : last_s;

  AESOneRound u_round (
    .in       (state_r),
    .roundkey (bus.rk_data),
    .dec      (mode_r),
    .nomix    (nomix_s),
    .out      (round_out_s)
  );

  // Block sequencing; rk_idx is registered one step ahead of the round that uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      state_r     <= 128'd0;
      out_data_r  <= 128'd0;
      cnt_r       <= 4'd0;
      rk_idx_r    <= 4'd0;
      mode_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.in_valid) begin
            mode_r     <= accept_dec_s;
            state_r    <= accept_dec_s ? bus.in_data : (bus.in_data ^ bus.rk_data);
            cnt_r      <= 4'd1;
            rk_idx_r   <= accept_dec_s ? NR_L : 4'd1;
            in_ready_r <= 1'b0;
            fsm_r      <= ROUND;
          end
        end
        ROUND: begin
          state_r <= round_out_s;
          if (last_s) begin
            rk_idx_r <= 4'd0;
            if (mode_r) begin
              fsm_r <= FINAL;
            end else begin
              out_data_r  <= round_out_s;
              out_valid_r <= 1'b1;
              fsm_r       <= DONE;
            end
          end else begin
            cnt_r    <= cnt_r + 4'd1;
            rk_idx_r <= mode_r ? (NR_L - cnt_r) : (cnt_r + 4'd1);
          end
        end
`ifdef AES_DEC_EN
        FINAL: begin
          out_data_r  <= state_r ^ bus.rk_data;
          out_valid_r <= 1'b1;
          fsm_r       <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            cnt_r       <= 4'd0;
            fsm_r       <= IDLE;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          rk_idx_r    <= 4'd0;
          cnt_r       <= 4'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.rk_idx    = rk_idx_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
endmodule

// One AES round, enc: Sub/Shift/[Mix]/ARK, dec: ARK/[InvMix]/InvShift/InvSub.
// S-boxes are computed as GF(2^8) inverse plus affine map.
module AESOneRound (
  input  logic [127:0] in,
  input  logic [127:0] roundkey,
  input  logic         dec,
  input  logic         nomix,
  output logic [127:0] out
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // x^254 = product of x^2 .. x^128; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] byte_at(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox(byte_at(s, 4*((c + r) % 4) + r));
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = xtime(byte_at(s, 4*c + r))
                                  ^ xtime(byte_at(s, 4*c + (r + 1) % 4)) ^ byte_at(s, 4*c + (r + 1) % 4)
                                  ^ byte_at(s, 4*c + (r + 2) % 4) ^ byte_at(s, 4*c + (r + 3) % 4);
    return o;
  endfunction

  logic [127:0] enc_sr_s;
  logic [127:0] enc_s;

  assign enc_sr_s = sub_shift(in);
  assign enc_s    = (nomix ? enc_sr_s : mix_columns(enc_sr_s)) ^ roundkey;

`ifdef AES_DEC_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(byte_at(s, 4*((c - r + 4) % 4) + r));
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = gmul(byte_at(s, 4*c + r), 8'h0e)
                                  ^ gmul(byte_at(s, 4*c + (r + 1) % 4), 8'h0b)
                                  ^ gmul(byte_at(s, 4*c + (r + 2) % 4), 8'h0d)
                                  ^ gmul(byte_at(s, 4*c + (r + 3) % 4), 8'h09);
    return o;
  endfunction

  logic [127:0] dec_ark_s;
  logic [127:0] dec_s;

  assign dec_ark_s = in ^ roundkey;
  assign dec_s     = inv_shift_sub(nomix ? dec_ark_s : inv_mix_columns(dec_ark_s));
  assign out       = dec ? dec_s : enc_s;
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign out        = enc_s;
`endif
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: three instances (NR=10/12/14) fed from a key store
// expanded here; FIPS-197 vectors, backpressure and mid-block reset sequences.
module tb_aes_iter_core;
`ifdef AES_DEC_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    int           k;
    logic         dec;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]        in_valid_a;
  logic [2:0]        in_dec_a;
  logic [2:0]        out_ready_a;
  logic [2:0][127:0] in_data_a;
  logic [2:0]        in_ready_o;
  logic [2:0]        out_valid_o;
  logic [2:0][3:0]   rk_idx_o;
  logic [2:0][127:0] out_data_o;
  logic [127:0]      rks [3][16];
  logic [127:0]      cts [3];
  vec_t              vecs [6];

  int n_vec  = 0;
  int n_miss = 0;
  int n_cmp  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_core_if bus ();
    assign bus.in_valid    = in_valid_a[g];
    assign bus.in_data     = in_data_a[g];
    assign bus.in_dec      = in_dec_a[g];
    assign bus.out_ready   = out_ready_a[g];
    assign bus.rk_data     = rks[g][bus.rk_idx];
    assign in_ready_o[g]   = bus.in_ready;
    assign out_valid_o[g]  = bus.out_valid;
    assign rk_idx_o[g]     = bus.rk_idx;
    assign out_data_o[g]   = bus.out_data;

    aes_iter_core #(.NR(10 + 2*g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(x) -: 8];
  endfunction

  task automatic expand(input int k, input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_idx(input int nr, input logic ed, input int n);
    if (n > nr) return 4'd0;
    return ed ? 4'(nr + 1 - n) : 4'(n);
  endfunction

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (out_valid_o[k] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out(input int k, input string name);
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[k] = 1'b0;
    chk({name, "_valid_drop"}, 128'(out_valid_o[k]), 128'd0);
    chk({name, "_ready_back"}, 128'(in_ready_o[k]), 128'd1);
  endtask

  task automatic run_block(input vec_t v, input string name);
    int  n;
    int  nr;
    logic ed;
    nr = 10 + 2*v.k;
    ed = v.dec & DEC;
    in_valid_a[v.k] = 1'b1;
    in_data_a[v.k]  = v.din;
    in_dec_a[v.k]   = v.dec;
    chk({name, "_in_ready"}, 128'(in_ready_o[v.k]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[v.k] = 1'b0;
    in_data_a[v.k]  = {$urandom, $urandom, $urandom, $urandom};
    in_dec_a[v.k]   = ~v.dec;
    n = 0;
    while (out_valid_o[v.k] !== 1'b1 && n < 40) begin
      n++;
      chk({name, "_rk_idx"}, 128'(rk_idx_o[v.k]), 128'(exp_idx(nr, ed, n)));
      @(posedge clk); #1;
    end
    chk({name, "_latency"}, 128'(n), 128'(v.lat));
    chk({name, "_data"}, out_data_o[v.k], v.exp);
    chk({name, "_busy"}, 128'(in_ready_o[v.k]), 128'd0);
    release_out(v.k, name);
    n_vec++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic seen;
    rst_n       = 1'b0;
    in_valid_a  = 3'b000;
    in_dec_a    = 3'b000;
    out_ready_a = 3'b000;
    in_data_a   = '{default: 128'd0};
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 16; r++) rks[k][r] = 128'd0;
    expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'd0});
    expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0});
    expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    cts[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    cts[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    cts[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int k = 0; k < 3; k++) begin
      vecs[2*k]   = '{k, 1'b0, PT, cts[k], 10 + 2*k};
      vecs[2*k+1] = DEC ? '{k, 1'b1, cts[k], PT, 11 + 2*k} : '{k, 1'b1, PT, cts[k], 10 + 2*k};
    end

    #12;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 128'(in_ready_o[k]), 128'd1);
      chk("reset_out_valid", 128'(out_valid_o[k]), 128'd0);
      chk("reset_out_data", out_data_o[k], 128'd0);
      chk("reset_rk_idx", 128'(rk_idx_o[k]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Backpressure on NR=10: a second block waits behind an unacknowledged result.
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = PT;
    in_dec_a[0]   = 1'b0;
    @(posedge clk); #1;
    wait_valid(0, n);
    chk("bp_latency", 128'(n), 128'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 128'(out_valid_o[0]), 128'd1);
      chk("bp_hold_data", out_data_o[0], cts[0]);
      chk("bp_hold_ready", 128'(in_ready_o[0]), 128'd0);
    end
    release_out(0, "bp_first");
    n_vec++;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    in_data_a[0]  = {$urandom, $urandom, $urandom, $urandom};
    chk("bp_second_accept", 128'(in_ready_o[0]), 128'd0);
    chk("bp_second_rk_idx", 128'(rk_idx_o[0]), 128'd1);
    wait_valid(0, n);
    chk("bp_second_latency", 128'(n), 128'd10);
    chk("bp_second_data", out_data_o[0], cts[0]);
    release_out(0, "bp_second");
    n_vec++;

    // Reset while round 5 is in flight: block must vanish without a result.
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = PT;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_rk_idx5", 128'(rk_idx_o[0]), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 128'(in_ready_o[0]), 128'd1);
    chk("rst_mid_out_valid", 128'(out_valid_o[0]), 128'd0);
    chk("rst_mid_out_data", out_data_o[0], 128'd0);
    chk("rst_mid_rk_idx", 128'(rk_idx_o[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen = seen | out_valid_o[0];
    end
    chk("rst_no_output", 128'(seen), 128'd0);
    n_vec++;
    run_block(vecs[0], "post_rst");
    run_block(vecs[1], "post_rst_dec");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
